// File: rtl/video_timing_pattern_gen.sv
// rtl/video_timing_pattern_gen.sv - programmable raster timing generator with test-pattern fill
//
// Purpose: drives a vs/hs/de + 3x8-bit pixel stream. Raster timing comes from
// 12-bit H/V counters, and the active area carries a selectable test pattern.
// All outputs are registered one clock after the counter state they decode.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   en           generator enable; low forces counters to 0 and outputs idle
//   pattern_sel  0 colour bars, 1 horizontal gradient, 2 checkerboard, 3 solid grey
//   vs, hs       vertical / horizontal sync (levels set by VS_POL / HS_POL)
//   de           active-video enable
//   pix_r/g/b    pixel channels (0 when de=0)
//   pix_x/pix_y  active column / line of current pixel (0 when de=0)
//   frame_start  one-cycle pulse on the output cycle of h_cnt=0, v_cnt=0
//
// Build option: define BORDER_OVERLAY_EN to force a one-pixel white border
// around the active area.

module video_timing_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic        vs,
  output logic        hs,
  output logic        de,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // 13-bit bounds so an active region ending exactly at 4096 still compares correctly.
  localparam logic [12:0] H_SYNC_END = 13'(H_SYNC);
  localparam logic [12:0] H_ACT_BEG  = 13'(H_SYNC + H_BP);
  localparam logic [12:0] H_ACT_END  = 13'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [12:0] V_SYNC_END = 13'(V_SYNC);
  localparam logic [12:0] V_ACT_BEG  = 13'(V_SYNC + V_BP);
  localparam logic [12:0] V_ACT_END  = 13'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] PX_OFF     = 12'(H_SYNC + H_BP);
  localparam logic [11:0] PY_OFF     = 12'(V_SYNC + V_BP);
  localparam int          BAR_W      = H_ACTIVE / 8;
  localparam logic [11:0] BAR_LAST   = 12'((BAR_W > 0) ? BAR_W - 1 : 0);
`ifdef BORDER_OVERLAY_EN
  localparam logic [11:0] PX_LAST    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] PY_LAST    = 12'(V_ACTIVE - 1);
`endif

  logic [11:0] h_cnt, v_cnt, h_next, v_next;
  logic        h_wrap;
  logic        act;          // counters running; first enabled clock only arms this
  logic        frame_origin;
  logic [1:0]  pat_q, pat_eff;
  logic [11:0] bar_cnt;
  logic [3:0]  bar_idx;      // 8 means past the last bar (remainder columns)
  logic [23:0] bar_rgb;

  logic        h_sync_d, v_sync_d, h_act_d, v_act_d, de_d;
  logic [11:0] px_d, py_d;
  logic [23:0] rgb_d;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_next = h_wrap ? 12'd0 : h_cnt + 12'd1;
    v_next = v_cnt;
    if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end
    frame_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    // The origin pixel itself must already see the newly sampled pattern.
    pat_eff = frame_origin ? pattern_sel : pat_q;
  end

  // Counters, pattern shadow and bar tracker. The bar tracker follows h_cnt so
  // it always describes the pixel the counters currently point at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= 12'd0;
      v_cnt   <= 12'd0;
      act     <= 1'b0;
      pat_q   <= 2'd0;
      bar_cnt <= 12'd0;
      bar_idx <= 4'd0;
    end else if (!en) begin
      h_cnt   <= 12'd0;
      v_cnt   <= 12'd0;
      act     <= 1'b0;
      bar_cnt <= 12'd0;
      bar_idx <= 4'd0;
    end else begin
      act <= 1'b1;
      if (act) begin
        h_cnt <= h_next;
        v_cnt <= v_next;
        if (frame_origin) begin
          pat_q <= pattern_sel;
        end
        if ({1'b0, h_next} == H_ACT_BEG) begin
          bar_cnt <= 12'd0;
          bar_idx <= 4'd0;
        end else if (bar_cnt == BAR_LAST) begin
          bar_cnt <= 12'd0;
          if (bar_idx != 4'd8) begin
            bar_idx <= bar_idx + 4'd1;
          end
        end else begin
          bar_cnt <= bar_cnt + 12'd1;
        end
      end
    end
  end

  always_comb begin
    case (bar_idx)
      4'd0:    bar_rgb = 24'hFFFFFF;
      4'd1:    bar_rgb = 24'hFFFF00;
      4'd2:    bar_rgb = 24'h00FFFF;
      4'd3:    bar_rgb = 24'h00FF00;
      4'd4:    bar_rgb = 24'hFF00FF;
      4'd5:    bar_rgb = 24'hFF0000;
      4'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    h_sync_d = ({1'b0, h_cnt} < H_SYNC_END);
    v_sync_d = ({1'b0, v_cnt} < V_SYNC_END);
    h_act_d  = ({1'b0, h_cnt} >= H_ACT_BEG) && ({1'b0, h_cnt} < H_ACT_END);
    v_act_d  = ({1'b0, v_cnt} >= V_ACT_BEG) && ({1'b0, v_cnt} < V_ACT_END);
    de_d     = h_act_d && v_act_d;
    px_d     = h_cnt - PX_OFF;
    py_d     = v_cnt - PY_OFF;
    rgb_d    = 24'h000000;
    if (de_d) begin
      case (pat_eff)
        2'd0:    rgb_d = bar_rgb;
        2'd1:    rgb_d = {px_d[7:0], px_d[7:0], px_d[7:0]};
        2'd2:    rgb_d = (px_d[4] ^ py_d[4]) ? 24'hFFFFFF : 24'h000000;
        default: rgb_d = 24'h808080;
      endcase
`ifdef BORDER_OVERLAY_EN
      if ((px_d == 12'd0) || (px_d == PX_LAST) || (py_d == 12'd0) || (py_d == PY_LAST)) begin
        rgb_d = 24'hFFFFFF;
      end
`endif
    end
  end

  // Output stage: idle values while disabled or on the arming clock after enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs          <= ~VS_POL;
      hs          <= ~HS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      pix_r       <= 8'd0;
      pix_g       <= 8'd0;
      pix_b       <= 8'd0;
      pix_x       <= 12'd0;
      pix_y       <= 12'd0;
    end else if (!en || !act) begin
      vs          <= ~VS_POL;
      hs          <= ~HS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      pix_r       <= 8'd0;
      pix_g       <= 8'd0;
      pix_b       <= 8'd0;
      pix_x       <= 12'd0;
      pix_y       <= 12'd0;
    end else begin
      vs          <= v_sync_d ? VS_POL : ~VS_POL;
      hs          <= h_sync_d ? HS_POL : ~HS_POL;
      de          <= de_d;
      frame_start <= frame_origin;
      pix_r       <= rgb_d[23:16];
      pix_g       <= rgb_d[15:8];
      pix_b       <= rgb_d[7:0];
      pix_x       <= de_d ? px_d : 12'd0;
      pix_y       <= de_d ? py_d : 12'd0;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb/tb_video_timing_pattern_gen.sv - scoreboard bench for video_timing_pattern_gen
module tb_video_timing_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en;
  logic [1:0] pattern_sel;

  logic        vs0, hs0, de0, fs0, vs1, hs1, de1, fs1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic [11:0] x0, y0, x1, y1;

  // Small raster, active-high syncs, 16 columns (bars are 2 wide).
  video_timing_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
    .vs(vs0), .hs(hs0), .de(de0), .pix_r(r0), .pix_g(g0), .pix_b(b0),
    .pix_x(x0), .pix_y(y0), .frame_start(fs0)
  );

  // Same vertical timing, 32 columns, active-low syncs.
  video_timing_pattern_gen #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
    .vs(vs1), .hs(hs1), .de(de1), .pix_r(r1), .pix_g(g1), .pix_b(b1),
    .pix_x(x1), .pix_y(y1), .frame_start(fs1)
  );

  // Packed expectation: {vs, hs, de, frame_start, rgb[23:0], x[11:0], y[11:0]}
  typedef struct packed {
    logic [51:0] val;
    logic        chk_xy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;

  bit         act_m [2];
  int         cnt_m [2];
  logic [1:0] pat_m [2];

  function automatic logic [23:0] bar_colour(int bar);
    case (bar)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // c = clock position within the frame (0 = first clock of sync line).
  function automatic logic [51:0] decode(int c, int ha, bit pol, logic [1:0] pat);
    int h, v, x, y, ht;
    logic de;
    logic [23:0] rgb;
    logic [11:0] xo, yo;
    ht  = 8 + ha;
    h   = c % ht;
    v   = c / ht;
    de  = (h >= 6) && (h < 6 + ha) && (v >= 3) && (v < 7);
    x   = h - 6;
    y   = v - 3;
    rgb = 24'h0;
    xo  = 12'h0;
    yo  = 12'h0;
    if (de) begin
      xo = 12'(x);
      yo = 12'(y);
      case (pat)
        2'd0:    rgb = bar_colour(x / (ha / 8));
        2'd1:    rgb = {xo[7:0], xo[7:0], xo[7:0]};
        2'd2:    rgb = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        default: rgb = 24'h808080;
      endcase
`ifdef BORDER_OVERLAY_EN
      if (x == 0 || x == ha - 1 || y == 0 || y == 3) rgb = 24'hFFFFFF;
`endif
    end
    return {((v < 2) ? pol : ~pol), ((h < 3) ? pol : ~pol), de, (c == 0), rgb, xo, yo};
  endfunction

  // Called right after each rising edge with the inputs the DUT just sampled.
  task automatic step(int id, int ha, bit pol);
    exp_t e;
    logic [1:0] p;
    if (!rst_n || !en || !act_m[id]) begin
      e.val      = {~pol, ~pol, 2'b00, 48'h0};
      e.chk_xy   = 1'b1;
      act_m[id]  = rst_n && en;
      cnt_m[id]  = 0;
    end else begin
      p = (cnt_m[id] == 0) ? pattern_sel : pat_m[id];
      if (cnt_m[id] == 0) pat_m[id] = pattern_sel;
      e.val     = decode(cnt_m[id], ha, pol, p);
      e.chk_xy  = e.val[49];
      cnt_m[id] = (cnt_m[id] + 1) % ((8 + ha) * 8);
    end
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic compare(int id, exp_t e, logic [51:0] got);
    logic [51:0] mask;
    mask = e.chk_xy ? {52{1'b1}} : {28'hFFFFFFF, 24'h0};
    n_tests++;
    if ((got & mask) !== (e.val & mask)) begin
      n_fail++;
      $display("FAIL dut%0d_outputs @%0t: got vs=%b hs=%b de=%b fs=%b rgb=%h x=%0d y=%0d, expected vs=%b hs=%b de=%b fs=%b rgb=%h x=%0d y=%0d%s",
               id, $time, got[51], got[50], got[49], got[48], got[47:24], got[23:12], got[11:0],
               e.val[51], e.val[50], e.val[49], e.val[48], e.val[47:24], e.val[23:12], e.val[11:0],
               e.chk_xy ? "" : " (x/y ignored)");
    end
  endtask

  // Monitor: pops one expectation per DUT per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, e, {vs0, hs0, de0, fs0, r0, g0, b0, x0, y0});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e, {vs1, hs1, de1, fs1, r1, g1, b1, x1, y1});
      end
    end
  end

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      step(0, 16, 1'b1);
      step(1, 32, 1'b0);
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    act_m[0] = 1'b0; act_m[1] = 1'b0;
    cnt_m[0] = 0;    cnt_m[1] = 0;
    pat_m[0] = 2'd0; pat_m[1] = 2'd0;
    rst_n = 1'b0; en = 1'b0; pattern_sel = 2'd0;
    run(3);
    rst_n = 1'b1; en = 1'b1;
    run(200);
    pattern_sel = 2'd2;   // mid-frame change: takes effect on the next frame
    run(500);
    pattern_sel = 2'd1;
    run(400);
    pattern_sel = 2'd3;
    run(350);
    en = 1'b0;            // dropped mid-line
    run(10);
    en = 1'b1;
    run(400);
    rst_n = 1'b0;         // same stimulus through reset
    run(10);
    rst_n = 1'b1;
    run(400);
    pattern_sel = 2'd0;
    run(700);
    en = 1'b0;
    run(5);
    repeat (3) @(negedge clk);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
